execute_sequencer: RTL and testbench

- Front-end controller for the 64-bit execute datapath.
- Accepts one operation per valid/ready handshake and drives the shared ALU's a/b/control inputs.
- Single-cycle ops (ADD, SUB, AND, ORR, PASSB) use the ALU for one cycle. MUL is a multi-cycle shift-add loop that reuses the ALU adder each iteration.
- Returns the result plus a zero flag on an output valid/ready handshake. Sits between decode and the memory stage.

---
 rtl/exec_pkg.sv | 51 +++++
 rtl/execute_sequencer.sv | 138 +++++++++++++
 tb/tb_execute_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared types and helpers for the execute-stage front end: opcodes, ALU
// control encodings, sequencer states and the op-to-ALU-control decode.
package exec_pkg;

    localparam int MUL_BITS_DEFAULT = 64;

    typedef logic [63:0] word_t;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_ORR   = 3'd3,
        OP_PASSB = 3'd4,
        OP_MUL   = 3'd5,
        OP_ILL6  = 3'd6,
        OP_ILL7  = 3'd7
    } op_e;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_ITER = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // True for the ops that complete in a single ALU cycle.
    function automatic logic op_is_single(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_ORR) || (op == OP_PASSB);
    endfunction

    // ALU control for a single-cycle op; non-ALU ops map to the idle code.
    function automatic logic [3:0] alu_ctrl(input op_e op);
        case (op)
            OP_ADD:   return ALU_ADD;
            OP_SUB:   return ALU_SUB;
            OP_AND:   return ALU_AND;
            OP_ORR:   return ALU_ORR;
            OP_PASSB: return ALU_PASSB;
            default:  return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/execute_sequencer.sv
// Execute-stage sequencer: accepts one op per handshake, drives the shared
// external ALU for single-cycle ops or a shift-add multiply loop, and
// presents the result with zero/error flags until the consumer takes it.
module execute_sequencer
    import exec_pkg::*;
#(
    parameter int MUL_BITS = MUL_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    output logic        alu_req,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [63:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        out_zero,
    output logic        out_err,
    output logic        busy
);

    localparam logic [6:0] LAST_ITER = 7'(MUL_BITS - 1);

    state_e     state_q,  state_d;
    op_e        op_q,     op_d;
    word_t      mcand_q,  mcand_d;   // operand A; shifted left while multiplying
    word_t      mplier_q, mplier_d;  // operand B; shifted right while multiplying
    word_t      acc_q,    acc_d;
    logic [6:0] count_q,  count_d;
    word_t      result_q, result_d;
    logic       err_q,    err_d;

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state, datapath updates and ALU drive; ALU inputs idle at zero.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_d    = result_q;
        err_d       = err_q;
        alu_req     = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_AND;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d     = op_e'(in_op);
                    mcand_d  = in_a;
                    mplier_d = in_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = (op_e'(in_op) == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_is_single(op_q)) begin
                    alu_req     = 1'b1;
                    alu_a       = mcand_q;
                    alu_b       = mplier_q;
                    alu_control = alu_ctrl(op_q);
                    result_d    = alu_result;
                    err_d       = 1'b0;
                end else begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_MUL_ITER: begin
                // Add the shifted multiplicand only for set multiplier bits.
                if (mplier_q[0]) begin
                    alu_req     = 1'b1;
                    alu_a       = acc_q;
                    alu_b       = mcand_q;
                    alu_control = ALU_ADD;
                    acc_d       = alu_result;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 7'd1;
                // Stop early once no multiplier bits remain.
                if ((mplier_d == '0) || (count_q == LAST_ITER)) begin
                    result_d = acc_d;
                    err_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = result_q;
    assign out_zero   = (result_q == '0);
    assign out_err    = err_q;

endmodule

// File: tb/tb_execute_sequencer.sv
// Bench for execute_sequencer: directed corner ops plus random ops, each
// compared against plain arithmetic expectations for result, flags,
// latency and ALU usage.
module tb_execute_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        alu_req;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_control;
    logic [63:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic        out_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    execute_sequencer #(.MUL_BITS(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_err(out_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared ALU
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_b;
            default: alu_result = 64'h0;
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_out_result"}, out_result, 64'd0);
        check_val({tag, "_out_zero"}, 64'(out_zero), 64'd1);
        check_val({tag, "_out_err"}, 64'(out_err), 64'd0);
        check_val({tag, "_alu_req"}, 64'(alu_req), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Issue one op, follow it to completion and check every cycle.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int stall, input bit junk);
        logic [63:0] exp_res;
        logic        exp_err;
        logic [3:0]  exp_ctrl;
        int          k;
        int          waited;
        logic        exp_req;

        exp_err  = 1'b0;
        exp_ctrl = 4'b0000;
        k        = 1;
        case (op)
            3'd0: begin exp_res = a + b; exp_ctrl = 4'b0010; end
            3'd1: begin exp_res = a - b; exp_ctrl = 4'b0110; end
            3'd2: begin exp_res = a & b; exp_ctrl = 4'b0000; end
            3'd3: begin exp_res = a | b; exp_ctrl = 4'b0001; end
            3'd4: begin exp_res = b;     exp_ctrl = 4'b0111; end
            3'd5: begin
                exp_res = a * b;
                for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
            end
            default: begin exp_res = 64'h0; exp_err = 1'b1; end
        endcase

        out_ready = (stall == 0);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check_val("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        // Inputs changing after accept must have no effect.
        in_valid = junk;
        in_op    = 3'($urandom);
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};

        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            if (op == 3'd5)       exp_req = b[c-1];
            else if (op <= 3'd4)  exp_req = 1'b1;
            else                  exp_req = 1'b0;
            check_val("busy_out_valid", 64'(out_valid), 64'd0);
            check_val("busy_in_ready", 64'(in_ready), 64'd0);
            check_val("busy_flag", 64'(busy), 64'd1);
            check_val("alu_req", 64'(alu_req), 64'(exp_req));
            if (exp_req && op != 3'd5) begin
                check_val("exec_alu_a", alu_a, a);
                check_val("exec_alu_b", alu_b, b);
                check_val("exec_alu_ctrl", 64'(alu_control), 64'(exp_ctrl));
            end else if (exp_req) begin
                check_val("mul_alu_ctrl", 64'(alu_control), 64'b0010);
            end else begin
                check_val("idle_alu_a", alu_a, 64'd0);
                check_val("idle_alu_b", alu_b, 64'd0);
                check_val("idle_alu_ctrl", 64'(alu_control), 64'd0);
            end
        end

        @(negedge clk);
        check_val("done_out_valid", 64'(out_valid), 64'd1);
        check_val("result", out_result, exp_res);
        check_val("zero", 64'(out_zero), 64'(exp_res == 64'h0));
        check_val("err", 64'(out_err), 64'(exp_err));
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            check_val("hold_out_valid", 64'(out_valid), 64'd1);
            check_val("hold_result", out_result, exp_res);
            check_val("hold_err", 64'(out_err), 64'(exp_err));
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("post_in_ready", 64'(in_ready), 64'd1);
        check_val("post_out_valid", 64'(out_valid), 64'd0);
        $display("txn op=%0d a=%h b=%h stall=%0d result=%h zero=%0d err=%0d",
                 op, a, b, stall, out_result, out_zero, out_err);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [63:0] r_a;
        logic [63:0] r_b;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 64'h0;
        in_b      = 64'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd0, 64'd5, 64'd7, 0, 1'b0);
        run_op(3'd1, 64'd9, 64'd9, 0, 1'b0);
        run_op(3'd1, 64'd0, 64'd1, 0, 1'b0);
        run_op(3'd5, 64'd3, 64'd5, 0, 1'b0);
        run_op(3'd5, 64'h1234, 64'd0, 0, 1'b0);
        run_op(3'd5, 64'd2, 64'h8000_0000_0000_0000, 0, 1'b0);
        run_op(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        run_op(3'd0, 64'd100, 64'd23, 5, 1'b1);
        run_op(3'd7, 64'hDEAD, 64'hBEEF, 0, 1'b0);
        run_op(3'd6, 64'h1, 64'h2, 2, 1'b1);
        run_op(3'd2, 64'hF0F0, 64'hFF00, 0, 1'b0);
        run_op(3'd3, 64'hF0F0, 64'h0F0F, 0, 1'b0);
        run_op(3'd4, 64'h1111, 64'h2222, 1, 1'b0);

        // Reset during the tenth multiply iteration.
        in_valid = 1'b1;
        in_op    = 3'd5;
        in_a     = 64'h77;
        in_b     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_val("mid_mul_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("after_reset");
        $display("txn reset during multiply iteration 10");
        run_op(3'd5, 64'd6, 64'd7, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
            r_b  = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) r_b = 64'h0;
            run_op(r_op, r_a, r_b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
